// File: rtl/keyboard_pkg.sv
// Shared constants, state encodings and event payload layout for the PS/2
// key event path.
package keyboard_pkg;

  localparam int unsigned SCAN_W  = 8;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned EVENT_W = SCAN_W + FLAGS_W;
  localparam int unsigned TO_W    = 16;

  localparam logic [SCAN_W-1:0] SC_E0     = 8'hE0;
  localparam logic [SCAN_W-1:0] SC_F0     = 8'hF0;
  localparam logic [SCAN_W-1:0] SC_FA     = 8'hFA;
  localparam logic [SCAN_W-1:0] SC_FE     = 8'hFE;
  localparam logic [SCAN_W-1:0] SC_AA     = 8'hAA;
  localparam logic [SCAN_W-1:0] SC_EE     = 8'hEE;
  localparam logic [SCAN_W-1:0] SC_FC     = 8'hFC;
  localparam logic [SCAN_W-1:0] SC_ED     = 8'hED;
  localparam logic [SCAN_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [SCAN_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [SCAN_W-1:0] SC_CAPS   = 8'h58;

  localparam int unsigned FLAG_EXT   = 3;
  localparam int unsigned FLAG_REL   = 2;
  localparam int unsigned FLAG_SHIFT = 1;
  localparam int unsigned FLAG_CAPS  = 0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_EXT,
    R_REL,
    R_EXT_REL
  } rx_state_e;

  typedef enum logic [2:0] {
    C_IDLE,
    C_SEND_ED,
    C_WAIT_ACK1,
    C_SEND_LED,
    C_WAIT_ACK2
  } cmd_state_e;

  typedef struct packed {
    logic [SCAN_W-1:0]  code;
    logic [FLAGS_W-1:0] flags;
  } key_event_t;

  // Keyboard status/ack bytes that never form a key event when unprefixed.
  function automatic logic is_status_byte(input logic [SCAN_W-1:0] b);
    return (b == SC_FA) || (b == SC_FE) || (b == SC_AA) || (b == SC_EE) ||
           (b == SC_FC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered storage; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module event_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/key_event_sequencer.sv
// Turns the raw PS/2 byte stream into buffered key events and drives the
// ED/LED command exchange whenever caps lock toggles.
module key_event_sequencer
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SCAN_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [SCAN_W-1:0] tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [SCAN_W-1:0] event_code,
  output logic [FLAGS_W-1:0] event_flags,
  output logic              event_valid,
  input  logic              event_ready,
  output logic              overflow,
  output logic              led_caps
);

  rx_state_e   r_state_q, r_state_d;
  cmd_state_e  c_state_q, c_state_d;

  logic        ev_done_c, ev_ext_c, ev_rel_c, cmd_ack_c, cmd_nak_c;
  logic        lshift_q, lshift_d, rshift_q, rshift_d;
  logic        caps_q, caps_d, caps_held_q, caps_held_d, caps_toggle_c;
  logic        led_pending_q, led_pending_d, led_clr_c, led_set_c;
  logic        overflow_q;
  key_event_t  ev_word_c, head;
  logic        fifo_empty, fifo_full, pop_c;

  logic [SCAN_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_start_q, tx_start_d;
  logic              sent_caps_q, sent_caps_d;
  logic              led_caps_q, led_caps_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              timeout_c;

  // Receive FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  // Receive FSM: next state
  always_comb begin
    r_state_d = r_state_q;
    if (rx_valid) begin
      case (r_state_q)
        R_IDLE: begin
          if (rx_byte == SC_E0)      r_state_d = R_EXT;
          else if (rx_byte == SC_F0) r_state_d = R_REL;
        end
        R_EXT:   r_state_d = (rx_byte == SC_F0) ? R_EXT_REL : R_IDLE;
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  // Receive FSM: event completion and command-response decode
  always_comb begin
    ev_done_c = 1'b0;
    ev_ext_c  = 1'b0;
    ev_rel_c  = 1'b0;
    cmd_ack_c = 1'b0;
    cmd_nak_c = 1'b0;
    if (rx_valid) begin
      case (r_state_q)
        R_IDLE: begin
          ev_done_c = !((rx_byte == SC_E0) || (rx_byte == SC_F0) || is_status_byte(rx_byte));
          cmd_ack_c = (rx_byte == SC_FA);
          cmd_nak_c = (rx_byte == SC_FE);
        end
        R_EXT: begin
          ev_done_c = (rx_byte != SC_F0);
          ev_ext_c  = 1'b1;
        end
        R_REL: begin
          ev_done_c = 1'b1;
          ev_rel_c  = 1'b1;
        end
        default: begin
          ev_done_c = 1'b1;
          ev_ext_c  = 1'b1;
          ev_rel_c  = 1'b1;
        end
      endcase
    end
  end

  // Modifier tracking; typematic caps repeats are masked by caps_held
  always_comb begin
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    caps_held_d   = caps_held_q;
    caps_toggle_c = 1'b0;
    if (ev_done_c && !ev_ext_c) begin
      case (rx_byte)
        SC_LSHIFT: lshift_d = !ev_rel_c;
        SC_RSHIFT: rshift_d = !ev_rel_c;
        SC_CAPS: begin
          caps_held_d   = !ev_rel_c;
          caps_toggle_c = !ev_rel_c && !caps_held_q;
        end
        default: ;
      endcase
    end
    caps_d = caps_q ^ caps_toggle_c;
  end

  always_comb begin
    ev_word_c                   = '0;
    ev_word_c.code              = rx_byte;
    ev_word_c.flags[FLAG_EXT]   = ev_ext_c;
    ev_word_c.flags[FLAG_REL]   = ev_rel_c;
    ev_word_c.flags[FLAG_SHIFT] = lshift_d | rshift_d;
    ev_word_c.flags[FLAG_CAPS]  = caps_d;
  end

  assign pop_c = !fifo_empty && event_ready;

  event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (ev_done_c),
    .wr_data_i (ev_word_c),
    .pop_i     (pop_c),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // Command FSM: state register
  always_ff @(posedge clk) begin
    if (reset) c_state_q <= C_IDLE;
    else       c_state_q <= c_state_d;
  end

  assign timeout_c = (cnt_q == TO_W'(ACK_TIMEOUT - 1));

  // Command FSM: next state
  always_comb begin
    c_state_d = c_state_q;
    case (c_state_q)
      C_IDLE:      if (led_pending_q) c_state_d = C_SEND_ED;
      C_SEND_ED:   if (!tx_busy) c_state_d = C_WAIT_ACK1;
      C_WAIT_ACK1: begin
        if (cmd_ack_c)      c_state_d = C_SEND_LED;
        else if (cmd_nak_c) c_state_d = C_SEND_ED;
        else if (timeout_c) c_state_d = C_IDLE;
      end
      C_SEND_LED:  if (!tx_busy) c_state_d = C_WAIT_ACK2;
      C_WAIT_ACK2: begin
        if (cmd_ack_c)      c_state_d = C_IDLE;
        else if (cmd_nak_c) c_state_d = C_SEND_LED;
        else if (timeout_c) c_state_d = C_IDLE;
      end
      default:     c_state_d = C_IDLE;
    endcase
  end

  // Command FSM: outputs and ack-timeout counter
  always_comb begin
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    sent_caps_d = sent_caps_q;
    led_caps_d  = led_caps_q;
    cnt_d       = '0;
    led_clr_c   = 1'b0;
    led_set_c   = 1'b0;
    case (c_state_q)
      C_SEND_ED: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_byte_d  = SC_ED;
        led_clr_c  = 1'b1;
      end
      C_SEND_LED: if (!tx_busy) begin
        tx_start_d  = 1'b1;
        tx_byte_d   = {5'b0, caps_q, 2'b00};
        sent_caps_d = caps_q;
      end
      C_WAIT_ACK1, C_WAIT_ACK2: begin
        if (!(cmd_ack_c || cmd_nak_c)) begin
          if (timeout_c) led_set_c = 1'b1;
          else           cnt_d     = cnt_q + TO_W'(1);
        end
        if ((c_state_q == C_WAIT_ACK2) && cmd_ack_c) led_caps_d = sent_caps_q;
      end
      default: ;
    endcase
  end

  // A toggle in the same cycle as ED launch keeps the request pending
  assign led_pending_d = (led_pending_q && !led_clr_c) || caps_toggle_c || led_set_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_q        <= 1'b0;
      caps_held_q   <= 1'b0;
      led_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      tx_byte_q     <= '0;
      tx_start_q    <= 1'b0;
      sent_caps_q   <= 1'b0;
      led_caps_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      caps_q        <= caps_d;
      caps_held_q   <= caps_held_d;
      led_pending_q <= led_pending_d;
      overflow_q    <= overflow_q || (ev_done_c && fifo_full && !pop_c);
      tx_byte_q     <= tx_byte_d;
      tx_start_q    <= tx_start_d;
      sent_caps_q   <= sent_caps_d;
      led_caps_q    <= led_caps_d;
      cnt_q         <= cnt_d;
    end
  end

  assign tx_byte     = tx_byte_q;
  assign tx_start    = tx_start_q;
  assign event_code  = head.code;
  assign event_flags = head.flags;
  assign event_valid = !fifo_empty;
  assign overflow    = overflow_q;
  assign led_caps    = led_caps_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Self-checking bench for key_event_sequencer: directed scenarios plus a
// randomized byte stream compared against a queue-based event model.
module tb_key_event_sequencer;

  localparam int FD = 4;
  localparam int AT = 40;

  logic       clk, reset, rx_valid, tx_start, tx_busy;
  logic [7:0] rx_byte, tx_byte, event_code;
  logic [3:0] event_flags;
  logic       event_valid, event_ready, overflow, led_caps;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [11:0] mq [$];
  logic [7:0]  tx_log [$];
  logic m_ext, m_rel, m_ls, m_rs, m_caps, m_held, m_ovf;
  logic [7:0] pool [12] = '{8'h1C, 8'h74, 8'h12, 8'h59, 8'h58, 8'hE0,
                            8'hF0, 8'hFA, 8'hFE, 8'hAA, 8'h00, 8'h2B};

  key_event_sequencer #(.FIFO_DEPTH(FD), .ACK_TIMEOUT(AT)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .event_code  (event_code),
    .event_flags (event_flags),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .overflow    (overflow),
    .led_caps    (led_caps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, advance the model, then compare outputs.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    logic        pop_now, push;
    logic [11:0] word;
    rx_valid = v; rx_byte = b; event_ready = rdy;
    pop_now = rdy && (mq.size() != 0);
    push = 1'b0;
    word = '0;
    if (v) begin
      if (!m_ext && !m_rel && (b == 8'hE0)) m_ext = 1'b1;
      else if (!m_rel && (b == 8'hF0)) m_rel = 1'b1;
      else if (!m_ext && !m_rel && (b inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'hFC, 8'h00, 8'hFF})) ;
      else begin
        if (!m_ext) begin
          if (b == 8'h12) m_ls = !m_rel;
          if (b == 8'h59) m_rs = !m_rel;
          if (b == 8'h58) begin
            if (!m_rel && !m_held) m_caps = !m_caps;
            m_held = !m_rel;
          end
        end
        word = {b, m_ext, m_rel, m_ls | m_rs, m_caps};
        push = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
    if (pop_now) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < FD) mq.push_back(word);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    if (tx_start === 1'b1) tx_log.push_back(tx_byte);
    check("event_valid", 32'(event_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("event_code", 32'(event_code), 32'(mq[0][11:4]));
      check("event_flags", 32'(event_flags), 32'(mq[0][3:0]));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; event_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst event_valid", 32'(event_valid), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst tx_start", 32'(tx_start), 0);
    check("rst led_caps", 32'(led_caps), 0);
    check("rst tx_byte", 32'(tx_byte), 0);
    check("rst event_code", 32'(event_code), 0);
    check("rst event_flags", 32'(event_flags), 0);
    reset = 1'b0;
    mq.delete();
    tx_log.delete();
    {m_ext, m_rel, m_ls, m_rs, m_caps, m_held, m_ovf} = '0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] code, input logic [3:0] flags);
    check({tag, " valid"}, 32'(event_valid), 1);
    check({tag, " code"}, 32'(event_code), 32'(code));
    check({tag, " flags"}, 32'(event_flags), 32'(flags));
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp, input int bound, output int waited);
    waited = 0;
    while (tx_log.size() == 0 && waited < bound) begin
      step(1'b0, 8'h00, 1'b1);
      waited++;
    end
    check({tag, " seen"}, 32'(tx_log.size() != 0), 1);
    if (tx_log.size() != 0) check(tag, 32'(tx_log.pop_front()), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clk = 1'b0; reset = 1'b1; rx_valid = 1'b0; rx_byte = '0;
    tx_busy = 1'b0; event_ready = 1'b0;
    do_reset();

    // Plain, extended and extended-break events
    step(1'b1, 8'h1C, 1'b0);
    check("latency valid", 32'(event_valid), 1);
    step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'h74, 1'b0);
    step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h74, 1'b0);
    pop_expect("ev1C", 8'h1C, 4'b0000);
    pop_expect("evE074", 8'h74, 4'b1000);
    pop_expect("evE0F074", 8'h74, 4'b1100);
    check("drained", 32'(event_valid), 0);

    // Shift make/break
    step(1'b1, 8'h12, 1'b0); step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h12, 1'b0); step(1'b1, 8'h1C, 1'b0);
    pop_expect("shift make", 8'h12, 4'b0010);
    pop_expect("shifted 1C", 8'h1C, 4'b0010);
    pop_expect("shift break", 8'h12, 4'b0100);
    pop_expect("unshifted 1C", 8'h1C, 4'b0000);

    // Caps with typematic repeat, LED command exchange
    do_reset();
    step(1'b1, 8'h58, 1'b1); step(1'b1, 8'h58, 1'b1); step(1'b1, 8'h58, 1'b1);
    step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h58, 1'b1);
    wait_tx("tx ED", 8'hED, 20, w);
    step(1'b1, 8'hFA, 1'b1);
    wait_tx("tx LED on", 8'h04, 20, w);
    check("led before ack", 32'(led_caps), 0);
    step(1'b1, 8'hFA, 1'b1);
    check("led after ack", 32'(led_caps), 1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    check("single sequence", 32'(tx_log.size()), 0);

    // Busy hold-off, resend, timeout retry
    do_reset();
    tx_busy = 1'b1;
    step(1'b1, 8'h58, 1'b1);
    repeat (10) step(1'b0, 8'h00, 1'b1);
    check("no tx while busy", 32'(tx_log.size()), 0);
    tx_busy = 1'b0;
    wait_tx("tx ED first", 8'hED, 20, w);
    step(1'b1, 8'hFE, 1'b1);
    wait_tx("tx ED resend", 8'hED, 20, w);
    wait_tx("tx ED retry", 8'hED, AT + 20, w);
    check("timeout length", 32'((w >= AT) && (w <= AT + 4)), 1);
    step(1'b1, 8'hFA, 1'b1);
    wait_tx("tx LED retry", 8'h04, 20, w);
    check("led pre-ack", 32'(led_caps), 0);
    step(1'b1, 8'hFA, 1'b1);
    check("led acked", 32'(led_caps), 1);

    // Overflow and full push with concurrent pop
    do_reset();
    repeat (5) step(1'b1, 8'h1C, 1'b0);
    check("overflow set", 32'(overflow), 1);
    step(1'b1, 8'h2B, 1'b1);
    pop_expect("ovf h0", 8'h1C, 4'b0000);
    pop_expect("ovf h1", 8'h1C, 4'b0000);
    pop_expect("ovf h2", 8'h1C, 4'b0000);
    pop_expect("ovf h3", 8'h2B, 4'b0000);
    check("ovf drained", 32'(event_valid), 0);
    check("overflow sticky", 32'(overflow), 1);

    // Reset mid-command and mid-prefix
    do_reset();
    step(1'b1, 8'h58, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    repeat (6) step(1'b0, 8'h00, 1'b1);
    check("cmd aborted", 32'(tx_log.size()), 0);
    step(1'b1, 8'hE0, 1'b0);
    do_reset();
    step(1'b1, 8'h74, 1'b0);
    check("post-reset code", 32'(event_code), 32'h74);
    check("post-reset flags", 32'(event_flags), 0);

    // Randomized byte stream against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 2) == 0 ? 0 : 1));
    end
    repeat (FD + 2) step(1'b0, 8'h00, 1'b1);
    check("random drained", 32'(event_valid), 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_sequencer.md
# key_event_sequencer

Sequences the raw PS/2 byte stream into complete key events for the CPU side of the keyboard FPGA. It strips E0/F0 prefix bytes, tracks shift and caps-lock state, and buffers events in a small FIFO behind a valid/ready handshake. It also drives the PS/2 transmitter through the ED/LED command sequence, with ack, resend and timeout handling, whenever caps lock toggles. It sits between the PS/2 receiver/transmitter and the ASCII decoding/CPU interface.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of 2, ≥2
- ACK_TIMEOUT, 50000, cycles to wait for keyboard FA before aborting a command byte
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- rx_byte  in  8  byte from PS/2 receiver
- rx_valid  in  1  one-cycle strobe qualifying rx_byte
- tx_byte  out  8  byte to PS/2 transmitter; held stable after tx_start
- tx_start  out  1  one-cycle pulse launching tx_byte
- tx_busy  in  1  transmitter busy; tx_start is never issued while high
- event_code  out  8  scan code of FIFO head
- event_flags  out  4  {extended, released, shift, caps} of FIFO head
- event_valid  out  1  FIFO not empty
- event_ready  in  1  consumer accepts head when valid & ready
- overflow  out  1  sticky; an event was dropped on a full FIFO
- led_caps  out  1  caps state last acknowledged by the keyboard

## Operation
- Receive FSM states: R_IDLE, R_EXT, R_REL, R_EXT_REL. Advances only on rx_valid.
  - R_IDLE: E0→R_EXT; F0→R_REL.
  - R_EXT: F0→R_EXT_REL.
  - Any other byte completes an event, with extended = state∈{R_EXT, R_EXT_REL} and released = state∈{R_REL, R_EXT_REL}, then returns to R_IDLE.
- In R_IDLE, bytes FA, FE, AA, EE, FC, 00 and FF are never pushed. FA and FE go to the command FSM; the rest are ignored.
- Modifiers apply to non-extended codes only.
  - 12 (left shift) and 59 (right shift): make sets, break clears that key's bit. shift = left | right.
  - 58 (caps): make toggles caps only if caps_held = 0, then sets caps_held. Break clears caps_held. Typematic repeats do not toggle.
  - Each toggle sets led_pending.
- Event flags carry shift/caps values after the event's own update.
- FIFO push on event completion.
  - If full and no pop in the same cycle: drop the event and set overflow.
  - If full with a pop in the same cycle: accept the push.
  - Pop on event_valid & event_ready.
- Command FSM states: C_IDLE, C_SEND_ED, C_WAIT_ACK1, C_SEND_LED, C_WAIT_ACK2.
  - C_IDLE: if led_pending → C_SEND_ED.
  - C_SEND_ED: when !tx_busy, pulse tx_start with tx_byte=ED, clear led_pending, go to C_WAIT_ACK1.
  - C_WAIT_ACK1: FA→C_SEND_LED; FE→C_SEND_ED (resend).
  - C_SEND_LED: when !tx_busy, send {5'b0, caps, 2'b00} using current caps, go to C_WAIT_ACK2.
  - C_WAIT_ACK2: FA→led_caps ← sent caps bit, then C_IDLE; FE→C_SEND_LED (resend).
  - Wait states: timeout after ACK_TIMEOUT cycles sets led_pending and returns to C_IDLE, so the sequence retries.
  - A toggle during a sequence sets led_pending, and a second sequence follows.
- FA/FE arriving while the command FSM is in a non-wait state is ignored.

## Timing
- Reset values:
  - Both FSMs idle; FIFO empty.
  - event_valid, overflow, tx_start, led_caps, shift, caps, caps_held, led_pending all 0.
  - tx_byte 00; event_code and event_flags 0.
- Reset mid-operation discards partial prefixes, FIFO contents and any in-flight command. No tx_start occurs in the reset cycle.
- Event latency: final byte rx_valid at cycle N → event_valid high at N+1, if the FIFO was empty.
- event_code and event_flags are driven from registered FIFO storage and are stable while event_valid & !event_ready.
- tx_start is exactly one cycle, asserted the cycle after the FSM observes !tx_busy in a SEND state.
- The timeout counter is 16-bit. It clears on entering a wait state and on FA/FE.

## Structure
- Shared package keyboard_pkg:
  - Scan/command constants: E0, F0, FA, FE, AA, EE, FC, ED, 12, 59, 58.
  - Receive and command state enums.
  - event_flags bit indices.
- Sub-module event_fifo: synchronous FIFO, parameterised width (12) and depth, with full/empty and simultaneous push/pop support.

## Test plan
- Bytes 1C; E0 74; E0 F0 74 → three events: 1C/flags 0000, 74/1000, 74/1100.
- Bytes 12, 1C, F0 12, 1C → 1C with shift=1, then F0 12 produces break 12 with shift=0, then 1C with shift=0.
- 58 58 58 F0 58 → caps toggles once; ED sent; FA → 04 sent; FA → led_caps=1.
- ED sent, respond FE → ED resent; then no FA for ACK_TIMEOUT cycles → abort, then ED re-sent.
- Push 5 events with event_ready=0 and FIFO_DEPTH=4 → 4 held, overflow=1. Full push concurrent with a pop is accepted.
- Reset asserted after E0 → next 74 yields event 74 with extended=0. All outputs return to reset values.
